// File: rtl/sdc_pkg.sv
// Shared SD card data-path definitions: command indices, error codes, tf_mode bits, sequencer states.
// Package only; it holds no logic and adds no latency.
package sdc_pkg;

    localparam logic [5:0] CMD12 = 6'd12;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD18 = 6'd18;

    localparam int TF_BLKCNT_EN = 1;
    localparam int TF_READ      = 4;
    localparam int TF_MULTI     = 5;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_CMD   = 3'd1,
        ERR_TMO   = 3'd2,
        ERR_CRC   = 3'd3,
        ERR_ARG   = 3'd4,
        ERR_ABORT = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RSP, S_WAIT_BLK, S_CHECK, S_STOP, S_STOP_RSP, S_DONE
    } state_e;

    function automatic logic [15:0] mk_cmd(input logic [5:0] idx, input logic [7:0] flgs);
        return {2'b00, idx, flgs};
    endfunction

    function automatic logic [15:0] mk_tf(input logic multi);
        logic [15:0] tf;
        tf               = '0;
        tf[TF_BLKCNT_EN] = 1'b1;
        tf[TF_READ]      = 1'b1;
        tf[TF_MULTI]     = multi;
        return tf;
    endfunction

endpackage

// File: rtl/sdc_crc16_ser.sv
// Serial CRC16-CCITT (x^16+x^12+x^5+1), init 0, MSB first; one bit per clock when en is high.
// Result is valid the cycle after the last enabled bit; clr takes priority over en.
module sdc_crc16_ser (
    input  logic        sdc_clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;

    assign fb = din ^ crc[15];

    always_ff @(posedge sdc_clk) begin
        if (reset || clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    end

endmodule

// File: rtl/sdc_rd_xfer_seq.sv
// SD read sequencer: issues CMD17/CMD18, times out and CRC-checks each block, stops multi-block reads with CMD12.
// cmd_req is held until cmd_ack; block results appear one cycle after rx_crc_strb.
import sdc_pkg::*;

module sdc_rd_xfer_seq #(
    parameter logic [23:0] TMO_CLKS  = 24'd2_500_000,
    parameter logic [7:0]  RESP_FLGS = 8'h1A,
    parameter logic [12:0] BLK_BITS  = 13'd4096
) (
    input  logic        sdc_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] blk_cnt,
    input  logic        d0_in,
    input  logic        abort,
    output logic        cmd_req,
    output logic [15:0] cmd_word,
    input  logic        cmd_ack,
    input  logic        cmd_done,
    input  logic        cmd_err,
    output logic [15:0] tf_mode,
    input  logic        rx_tfc,
    input  logic        rx_crc_strb,
    input  logic [15:0] rx_crc,
    output logic        blk_done,
    output logic [15:0] blks_left,
    output logic        busy,
    output logic        done_strb,
    output logic [2:0]  err_code
);

    state_e      state, state_nxt, err_exit;
    err_e        err_q, err_val;
    logic        err_set, blk_ok, sbit_take, tmo_hit;
    logic        multi_q, d0_prev, rcv, seen;
    logic [23:0] tmo_q;
    logic [12:0] bit_cnt;
    logic [15:0] crc_loc, cmd_word_q, tf_mode_q, blks_left_q;

    assign err_exit  = multi_q ? S_STOP : S_DONE;
    assign sbit_take = (state == S_WAIT_BLK) && !abort && !seen && d0_prev && !d0_in;
    assign tmo_hit   = (state == S_WAIT_BLK) && !seen && (tmo_q <= 24'd1);

    always_ff @(posedge sdc_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_val   = ERR_NONE;
        blk_ok    = 1'b0;
        cmd_req   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                err_set = 1'b1;
                if (blk_cnt == 16'd0) begin
                    err_val   = ERR_ARG;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_req = 1'b1;
                if (cmd_ack) state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: if (abort) begin
                err_set = 1'b1; err_val = ERR_ABORT; state_nxt = err_exit;
            end else if (cmd_done) begin
                if (cmd_err) begin
                    err_set = 1'b1; err_val = ERR_CMD; state_nxt = S_DONE;
                end else begin
                    state_nxt = S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: if (abort) begin
                err_set = 1'b1; err_val = ERR_ABORT; state_nxt = err_exit;
            end else if (!sbit_take && tmo_hit) begin
                err_set = 1'b1; err_val = ERR_TMO; state_nxt = err_exit;
            end else if (seen && rx_crc_strb) begin
                // A strobe before any start bit would compare a stale CRC, so it is ignored.
                state_nxt = S_CHECK;
            end
            S_CHECK: if (abort) begin
                err_set = 1'b1; err_val = ERR_ABORT; state_nxt = err_exit;
            end else if (rx_crc == crc_loc) begin
                blk_ok    = 1'b1;
                state_nxt = (blks_left_q <= 16'd1) ? err_exit : S_WAIT_BLK;
            end else begin
                err_set = 1'b1; err_val = ERR_CRC; state_nxt = err_exit;
            end
            S_STOP: begin
                cmd_req = 1'b1;
                if (cmd_ack) state_nxt = S_STOP_RSP;
            end
            S_STOP_RSP: if (cmd_done) begin
                if (cmd_err && err_q == ERR_NONE) begin
                    err_set = 1'b1; err_val = ERR_CMD;
                end
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sdc_clk) begin
        if (reset) begin
            err_q       <= ERR_NONE;
            multi_q     <= 1'b0;
            d0_prev     <= 1'b1;
            rcv         <= 1'b0;
            seen        <= 1'b0;
            tmo_q       <= 24'd0;
            bit_cnt     <= 13'd0;
            cmd_word_q  <= 16'h0000;
            tf_mode_q   <= 16'h0000;
            blks_left_q <= 16'h0000;
        end else begin
            d0_prev <= d0_in;
            if (err_set) err_q <= err_val;

            if (state == S_IDLE && start) begin
                blks_left_q <= blk_cnt;
                if (blk_cnt != 16'd0) begin
                    multi_q    <= (blk_cnt != 16'd1);
                    cmd_word_q <= mk_cmd((blk_cnt == 16'd1) ? CMD17 : CMD18, RESP_FLGS);
                    tf_mode_q  <= mk_tf(blk_cnt != 16'd1);
                end
            end else if (blk_ok && blks_left_q != 16'd0) begin
                blks_left_q <= blks_left_q - 16'd1;
            end

            if (state_nxt == S_STOP && state != S_STOP) begin
                cmd_word_q <= mk_cmd(CMD12, RESP_FLGS);
                tf_mode_q  <= 16'h0000;
            end else if (state_nxt == S_DONE) begin
                tf_mode_q  <= 16'h0000;
            end

            // The timeout window restarts at each command ack and after every accepted block.
            if ((state == S_ISSUE && cmd_ack) || (state == S_CHECK && state_nxt == S_WAIT_BLK)) begin
                tmo_q <= TMO_CLKS;
            end else if (state == S_WAIT_BLK && !seen && tmo_q != 24'd0) begin
                tmo_q <= tmo_q - 24'd1;
            end

            seen <= (state_nxt == S_WAIT_BLK) && (seen || sbit_take);

            if (sbit_take) begin
                rcv     <= 1'b1;
                bit_cnt <= 13'd0;
            end else if (state_nxt != S_WAIT_BLK || rx_tfc) begin
                rcv <= 1'b0;
            end else if (rcv) begin
                bit_cnt <= bit_cnt + 13'd1;
                if (bit_cnt == BLK_BITS - 13'd1) rcv <= 1'b0;
            end
        end
    end

    sdc_crc16_ser u_crc (
        .sdc_clk (sdc_clk),
        .reset   (reset),
        .clr     (sbit_take),
        .en      (rcv),
        .din     (d0_in),
        .crc     (crc_loc)
    );

    assign cmd_word  = cmd_word_q;
    assign tf_mode   = tf_mode_q;
    assign blks_left = blks_left_q;
    assign blk_done  = blk_ok;
    assign busy      = (state != S_IDLE);
    assign done_strb = (state == S_DONE);
    assign err_code  = err_q;

endmodule
